// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer
// Description : Turn sequencer for a two-player throwing duel: aim, charge,
//               launch, flight, resolve, inter-turn gap and game over.
// Revision    : 1.0 - initial release
// ============================================================================
module round_sequencer #(
    parameter logic [7:0] HP_INIT           = 8'd100,
    parameter logic [7:0] DAMAGE            = 8'd20,
    parameter logic [7:0] POWER_STEP        = 8'd4,
    parameter logic [9:0] FLIGHT_TIMEOUT_FR = 10'd180,
    parameter logic [9:0] GAP_FR            = 10'd60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       space,
    input  logic       frame_tick,
    input  logic       throw_done,
    input  logic       hit,
    output logic       dog_turn,
    output logic       cat_turn,
    output logic       charging,
    output logic [7:0] power,
    output logic       throw_start,
    output logic [7:0] throw_power,
    output logic [7:0] hp_dog,
    output logic [7:0] hp_cat,
    output logic       game_over,
    output logic       winner
);

    localparam logic [2:0] c_s_aim     = 3'd0;
    localparam logic [2:0] c_s_charge  = 3'd1;
    localparam logic [2:0] c_s_launch  = 3'd2;
    localparam logic [2:0] c_s_flight  = 3'd3;
    localparam logic [2:0] c_s_resolve = 3'd4;
    localparam logic [2:0] c_s_gap     = 3'd5;
    localparam logic [2:0] c_s_over    = 3'd6;

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic       r_space_d;
    logic       r_turn;          // 0 = dog throwing, 1 = cat throwing
    logic       r_hit_latch;
    logic [9:0] r_frame_cnt;
    logic       r_dog_turn;
    logic       r_cat_turn;
    logic       r_charging;
    logic [7:0] r_power;
    logic       r_throw_start;
    logic [7:0] r_throw_power;
    logic [7:0] r_hp_dog;
    logic [7:0] r_hp_cat;
    logic       r_game_over;
    logic       r_winner;

    logic       w_space_rise;
    logic [9:0] w_frame_inc;
    logic       w_flight_timeout;
    logic       w_gap_done;
    logic       w_any_dead;
    logic [8:0] w_power_sum;
    logic       w_turn_next;
    logic       w_hit_latch_next;
    logic [9:0] w_frame_cnt_next;
    logic [7:0] w_power_next;
    logic [7:0] w_throw_power_next;
    logic [7:0] w_hp_dog_next;
    logic [7:0] w_hp_cat_next;
    logic       w_winner_next;
    logic       w_in_turn;

    assign w_space_rise     = space & ~r_space_d;
    assign w_frame_inc      = r_frame_cnt + 10'd1;
    assign w_flight_timeout = frame_tick && (w_frame_inc == FLIGHT_TIMEOUT_FR);
    assign w_gap_done       = frame_tick && (w_frame_inc == GAP_FR);
    assign w_any_dead       = (r_hp_dog == 8'd0) || (r_hp_cat == 8'd0);
    assign w_power_sum      = {1'b0, r_power} + {1'b0, POWER_STEP};

    always_ff @(posedge clk) begin
        // Sampling space during reset too means a key held through reset
        // must be released before it can start a charge.
        r_space_d <= space;
        if (rst) begin
            r_state       <= c_s_aim;
            r_turn        <= 1'b0;
            r_hit_latch   <= 1'b0;
            r_frame_cnt   <= 10'd0;
            r_dog_turn    <= 1'b1;
            r_cat_turn    <= 1'b0;
            r_charging    <= 1'b0;
            r_power       <= 8'd0;
            r_throw_start <= 1'b0;
            r_throw_power <= 8'd0;
            r_hp_dog      <= HP_INIT;
            r_hp_cat      <= HP_INIT;
            r_game_over   <= 1'b0;
            r_winner      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_turn        <= w_turn_next;
            r_hit_latch   <= w_hit_latch_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_dog_turn    <= w_in_turn & ~w_turn_next;
            r_cat_turn    <= w_in_turn & w_turn_next;
            r_charging    <= (w_state_next == c_s_charge);
            r_power       <= w_power_next;
            r_throw_start <= (w_state_next == c_s_launch);
            r_throw_power <= w_throw_power_next;
            r_hp_dog      <= w_hp_dog_next;
            r_hp_cat      <= w_hp_cat_next;
            r_game_over   <= (w_state_next == c_s_over);
            r_winner      <= w_winner_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_s_aim:     if (w_space_rise) w_state_next = c_s_charge;
            c_s_charge:  if (!space) w_state_next = c_s_launch;
            c_s_launch:  w_state_next = c_s_flight;
            c_s_flight:  if (throw_done || w_flight_timeout) w_state_next = c_s_resolve;
            c_s_resolve: w_state_next = c_s_gap;
            c_s_gap: begin
                if (w_any_dead)      w_state_next = c_s_over;
                else if (w_gap_done) w_state_next = c_s_aim;
            end
            c_s_over:    w_state_next = c_s_over;
            default:     w_state_next = c_s_aim;
        endcase
    end

    always_comb begin
        w_turn_next        = r_turn;
        w_hit_latch_next   = r_hit_latch;
        w_frame_cnt_next   = r_frame_cnt;
        w_power_next       = r_power;
        w_throw_power_next = r_throw_power;
        w_hp_dog_next      = r_hp_dog;
        w_hp_cat_next      = r_hp_cat;
        w_winner_next      = r_winner;
        case (r_state)
            c_s_aim: begin
                if (w_space_rise) w_power_next = 8'd0;
            end
            c_s_charge: begin
                // A frame_tick coinciding with release is deliberately dropped.
                if (!space)          w_throw_power_next = r_power;
                else if (frame_tick) w_power_next = w_power_sum[8] ? 8'hFF : w_power_sum[7:0];
            end
            c_s_launch: begin
                w_hit_latch_next = 1'b0;
                w_frame_cnt_next = 10'd0;
            end
            c_s_flight: begin
                w_hit_latch_next = r_hit_latch | hit;
                if (frame_tick) w_frame_cnt_next = w_frame_inc;
            end
            c_s_resolve: begin
                w_frame_cnt_next = 10'd0;
                if (r_hit_latch) begin
                    if (r_turn) w_hp_dog_next = (r_hp_dog > DAMAGE) ? (r_hp_dog - DAMAGE) : 8'd0;
                    else        w_hp_cat_next = (r_hp_cat > DAMAGE) ? (r_hp_cat - DAMAGE) : 8'd0;
                end
            end
            c_s_gap: begin
                if (frame_tick) w_frame_cnt_next = w_frame_inc;
                if (w_state_next == c_s_aim) w_turn_next = ~r_turn;
                if (w_state_next == c_s_over) w_winner_next = r_turn;
            end
            default: begin
            end
        endcase
        w_in_turn = (w_state_next == c_s_aim)    || (w_state_next == c_s_charge) ||
                    (w_state_next == c_s_launch) || (w_state_next == c_s_flight) ||
                    (w_state_next == c_s_resolve);
    end

    assign dog_turn    = r_dog_turn;
    assign cat_turn    = r_cat_turn;
    assign charging    = r_charging;
    assign power       = r_power;
    assign throw_start = r_throw_start;
    assign throw_power = r_throw_power;
    assign hp_dog      = r_hp_dog;
    assign hp_cat      = r_hp_cat;
    assign game_over   = r_game_over;
    assign winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_sequencer
// Description : Scenario tasks plus a randomized match checked against a
//               turn-level model of hit points, turns and throw power.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_sequencer;

    localparam logic [7:0] HP_INIT           = 8'd100;
    localparam logic [7:0] DAMAGE            = 8'd20;
    localparam logic [7:0] POWER_STEP        = 8'd4;
    localparam logic [9:0] FLIGHT_TIMEOUT_FR = 10'd180;
    localparam logic [9:0] GAP_FR            = 10'd60;

    logic       clk = 1'b0;
    logic       rst, space, frame_tick, throw_done, hit;
    logic       dog_turn, cat_turn, charging, throw_start, game_over, winner;
    logic [7:0] power, throw_power, hp_dog, hp_cat;

    int n_cmp = 0;
    int n_err = 0;

    int m_hp[2];
    int m_turn;
    int m_over;
    int m_winner;

    round_sequencer #(
        .HP_INIT(HP_INIT), .DAMAGE(DAMAGE), .POWER_STEP(POWER_STEP),
        .FLIGHT_TIMEOUT_FR(FLIGHT_TIMEOUT_FR), .GAP_FR(GAP_FR)
    ) dut (
        .clk(clk), .rst(rst), .space(space), .frame_tick(frame_tick),
        .throw_done(throw_done), .hit(hit), .dog_turn(dog_turn), .cat_turn(cat_turn),
        .charging(charging), .power(power), .throw_start(throw_start),
        .throw_power(throw_power), .hp_dog(hp_dog), .hp_cat(hp_cat),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_tick = 1'b1; tick();
        frame_tick = 1'b0; tick();
    endtask

    function automatic int exp_power(input int n);
        return (n * int'(POWER_STEP) > 255) ? 255 : n * int'(POWER_STEP);
    endfunction

    task automatic model_reset();
        m_hp[0] = int'(HP_INIT); m_hp[1] = int'(HP_INIT);
        m_turn = 0; m_over = 0; m_winner = 0;
    endtask

    task automatic model_resolve(input int was_hit);
        int victim;
        victim = 1 - m_turn;
        if (was_hit != 0) m_hp[victim] = (m_hp[victim] > int'(DAMAGE)) ? m_hp[victim] - int'(DAMAGE) : 0;
        if (m_hp[0] == 0 || m_hp[1] == 0) begin
            m_over = 1; m_winner = m_turn;
        end
    endtask

    task automatic model_gap();
        if (m_over == 0) m_turn = 1 - m_turn;
    endtask

    task automatic do_reset();
        space = 1'b0; frame_tick = 1'b0; throw_done = 1'b0; hit = 1'b0;
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        model_reset();
    endtask

    // mode: 0 miss+done, 1 hit&done same cycle, 2 hit then done, 3 timeout miss, 4 hit then timeout
    task automatic play_turn(input int nticks, input int mode, output int starts,
                             output logic [7:0] tp, output logic [7:0] pw,
                             output logic [1:0] fturn, output logic flag_before);
        starts = 0;
        space = 1'b1; tick();
        for (int i = 0; i < nticks; i++) pulse_frame();
        space = 1'b0; frame_tick = 1'b1; tick(); frame_tick = 1'b0;
        if (throw_start) starts++;
        tick();
        if (throw_start) starts++;
        tp = throw_power; pw = power; fturn = {cat_turn, dog_turn};
        if (mode >= 3) begin
            if (mode == 4) begin hit = 1'b1; tick(); hit = 1'b0; end
            for (int i = 0; i < int'(FLIGHT_TIMEOUT_FR) - 1; i++) begin
                pulse_frame();
                if (throw_start) starts++;
            end
            flag_before = dog_turn | cat_turn;
            pulse_frame();
        end else begin
            if (mode == 2) begin hit = 1'b1; tick(); hit = 1'b0; pulse_frame(); pulse_frame(); end
            flag_before = dog_turn | cat_turn;
            hit = (mode == 1); throw_done = 1'b1; tick();
            hit = 1'b0; throw_done = 1'b0;
            tick();
        end
        if (throw_start) starts++;
    endtask

    task automatic run_gap(output logic flags_late);
        for (int i = 0; i < int'(GAP_FR) - 1; i++) begin
            hit = 1'($urandom_range(0, 1)); throw_done = 1'($urandom_range(0, 1));
            pulse_frame();
            hit = 1'b0; throw_done = 1'b0;
        end
        flags_late = dog_turn | cat_turn;
        pulse_frame();
    endtask

    task automatic test_reset();
        logic [37:0] obs;
        do_reset();
        space = 1'b1; tick();
        pulse_frame(); pulse_frame(); pulse_frame();
        n_cmp++;
        if (power !== 8'd12) begin n_err++; $display("FAIL reset_precharge_power: got %0d expected 12", power); end
        do_reset();
        obs = {dog_turn, cat_turn, charging, throw_start, game_over, winner, power, throw_power, hp_dog, hp_cat};
        n_cmp++;
        if (obs !== {6'b100000, 8'd0, 8'd0, HP_INIT, HP_INIT}) begin
            n_err++; $display("FAIL reset_values: got %h expected %h", obs, {6'b100000, 8'd0, 8'd0, HP_INIT, HP_INIT});
        end
    endtask

    task automatic test_basic_throw();
        int starts; logic [7:0] tp, pw; logic [1:0] ft; logic fb, f59;
        do_reset();
        play_turn(10, 0, starts, tp, pw, ft, fb);
        n_cmp++;
        if (starts !== 1) begin n_err++; $display("FAIL basic_start_count: got %0d expected 1", starts); end
        n_cmp++;
        if (tp !== 8'd40) begin n_err++; $display("FAIL basic_throw_power: got %0d expected 40", tp); end
        n_cmp++;
        if (ft !== 2'b01) begin n_err++; $display("FAIL basic_dog_turn: got %b expected 01", ft); end
        n_cmp++;
        if (power !== 8'd40 || throw_power !== 8'd40) begin
            n_err++; $display("FAIL basic_power_hold: got %0d/%0d expected 40/40", power, throw_power);
        end
        model_resolve(0);
        n_cmp++;
        if (hp_cat !== 8'(m_hp[1]) || hp_dog !== 8'(m_hp[0])) begin
            n_err++; $display("FAIL basic_hp: got %0d/%0d expected %0d/%0d", hp_dog, hp_cat, m_hp[0], m_hp[1]);
        end
        run_gap(f59);
        model_gap();
        n_cmp++;
        if (f59 !== 1'b0) begin n_err++; $display("FAIL basic_gap_flags: got %b expected 0", f59); end
        n_cmp++;
        if ({cat_turn, dog_turn} !== 2'b10) begin n_err++; $display("FAIL basic_turn_pass: got %b expected 10", {cat_turn, dog_turn}); end
    endtask

    task automatic test_saturation();
        do_reset();
        space = 1'b1; tick();
        n_cmp++;
        if (charging !== 1'b1 || power !== 8'd0) begin
            n_err++; $display("FAIL sat_charge_entry: got charging=%b power=%0d expected 1/0", charging, power);
        end
        for (int k = 1; k <= 70; k++) begin
            pulse_frame();
            n_cmp++;
            if (power !== 8'(exp_power(k))) begin
                n_err++; $display("FAIL sat_power_frame%0d: got %0d expected %0d", k, power, exp_power(k));
            end
        end
        space = 1'b0; tick();
        n_cmp++;
        if (throw_start !== 1'b1 || throw_power !== 8'd255 || charging !== 1'b0) begin
            n_err++; $display("FAIL sat_launch: got start=%b tp=%0d chg=%b expected 1/255/0", throw_start, throw_power, charging);
        end
        tick();
        n_cmp++;
        if (throw_start !== 1'b0) begin n_err++; $display("FAIL sat_start_width: got %b expected 0", throw_start); end
    endtask

    task automatic test_hit_same_cycle();
        int starts; logic [7:0] tp, pw; logic [1:0] ft; logic fb, f59;
        do_reset();
        play_turn(7, 1, starts, tp, pw, ft, fb);
        model_resolve(1);
        n_cmp++;
        if (hp_cat !== 8'd80 || hp_dog !== 8'd100) begin
            n_err++; $display("FAIL same_cycle_hp: got %0d/%0d expected 100/80", hp_dog, hp_cat);
        end
        run_gap(f59);
        model_gap();
        n_cmp++;
        if ({cat_turn, dog_turn} !== 2'b10) begin n_err++; $display("FAIL same_cycle_turn: got %b expected 10", {cat_turn, dog_turn}); end
    endtask

    task automatic test_timeout();
        int starts; logic [7:0] tp, pw; logic [1:0] ft; logic fb, f59;
        do_reset();
        play_turn(5, 3, starts, tp, pw, ft, fb);
        n_cmp++;
        if (fb !== 1'b1) begin n_err++; $display("FAIL timeout_early_end: got flag %b expected 1", fb); end
        n_cmp++;
        if ({cat_turn, dog_turn} !== 2'b00) begin n_err++; $display("FAIL timeout_in_gap: got %b expected 00", {cat_turn, dog_turn}); end
        n_cmp++;
        if (hp_dog !== HP_INIT || hp_cat !== HP_INIT) begin
            n_err++; $display("FAIL timeout_hp: got %0d/%0d expected 100/100", hp_dog, hp_cat);
        end
        run_gap(f59);
        n_cmp++;
        if ({cat_turn, dog_turn} !== 2'b10) begin n_err++; $display("FAIL timeout_turn: got %b expected 10", {cat_turn, dog_turn}); end
    endtask

    task automatic test_game_over();
        int starts, seen_start; logic [7:0] tp, pw; logic [1:0] ft; logic fb, f59;
        do_reset();
        for (int t = 0; t < 12 && m_over == 0; t++) begin
            play_turn($urandom_range(1, 20), (m_turn == 0) ? 1 : 0, starts, tp, pw, ft, fb);
            model_resolve((m_turn == 0) ? 1 : 0);
            n_cmp++;
            if (hp_cat !== 8'(m_hp[1]) || hp_dog !== 8'(m_hp[0])) begin
                n_err++; $display("FAIL over_hp_turn%0d: got %0d/%0d expected %0d/%0d", t, hp_dog, hp_cat, m_hp[0], m_hp[1]);
            end
            if (m_over == 0) begin run_gap(f59); model_gap(); end
        end
        tick();
        n_cmp++;
        if ({game_over, winner, cat_turn, dog_turn} !== {1'b1, 1'(m_winner), 2'b00} || hp_cat !== 8'd0) begin
            n_err++; $display("FAIL over_state: got go=%b win=%b turns=%b hp_cat=%0d expected 1/0/00/0",
                              game_over, winner, {cat_turn, dog_turn}, hp_cat);
        end
        seen_start = 0;
        space = 1'b1;
        for (int i = 0; i < 5; i++) begin
            hit = 1'b1; throw_done = 1'b1; pulse_frame();
            if (throw_start || charging) seen_start++;
        end
        space = 1'b0; hit = 1'b0; throw_done = 1'b0; tick();
        n_cmp++;
        if (seen_start !== 0 || game_over !== 1'b1 || hp_dog !== 8'd100 || hp_cat !== 8'd0) begin
            n_err++; $display("FAIL over_ignores_inputs: got activity=%0d go=%b hp=%0d/%0d expected 0/1/100/0",
                              seen_start, game_over, hp_dog, hp_cat);
        end
    endtask

    task automatic test_reset_mid();
        int starts, seen; logic [7:0] tp, pw; logic [1:0] ft; logic fb, f59;
        logic [37:0] obs;
        do_reset();
        play_turn(3, 1, starts, tp, pw, ft, fb);
        run_gap(f59);
        space = 1'b1; tick();
        pulse_frame(); pulse_frame(); pulse_frame();
        space = 1'b0; tick(); tick();
        rst = 1'b1; hit = 1'b1; throw_done = 1'b1; tick();
        rst = 1'b0; hit = 1'b0; throw_done = 1'b0;
        model_reset();
        obs = {dog_turn, cat_turn, charging, throw_start, game_over, winner, power, throw_power, hp_dog, hp_cat};
        n_cmp++;
        if (obs !== {6'b100000, 8'd0, 8'd0, HP_INIT, HP_INIT}) begin
            n_err++; $display("FAIL reset_flight_values: got %h expected %h", obs, {6'b100000, 8'd0, 8'd0, HP_INIT, HP_INIT});
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin pulse_frame(); if (throw_start) seen++; end
        n_cmp++;
        if (seen !== 0 || hp_dog !== HP_INIT || hp_cat !== HP_INIT) begin
            n_err++; $display("FAIL reset_flight_after: got starts=%0d hp=%0d/%0d expected 0/100/100", seen, hp_dog, hp_cat);
        end
        space = 1'b1; tick(); pulse_frame(); pulse_frame();
        rst = 1'b1; tick(); rst = 1'b0;
        obs = {dog_turn, cat_turn, charging, throw_start, game_over, winner, power, throw_power, hp_dog, hp_cat};
        n_cmp++;
        if (obs !== {6'b100000, 8'd0, 8'd0, HP_INIT, HP_INIT}) begin
            n_err++; $display("FAIL reset_charge_values: got %h expected %h", obs, {6'b100000, 8'd0, 8'd0, HP_INIT, HP_INIT});
        end
        seen = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (charging) seen++; end
        n_cmp++;
        if (seen !== 0) begin n_err++; $display("FAIL reset_held_key: got %0d charging cycles expected 0", seen); end
        space = 1'b0; tick(); space = 1'b1; tick();
        n_cmp++;
        if (charging !== 1'b1) begin n_err++; $display("FAIL reset_repress: got charging=%b expected 1", charging); end
        space = 1'b0; tick();
    endtask

    task automatic test_random_match();
        int n, mode, starts; logic [7:0] tp, pw; logic [1:0] ft; logic fb, f59;
        do_reset();
        for (int t = 0; t < 20 && m_over == 0; t++) begin
            n = $urandom_range(0, 80);
            mode = $urandom_range(0, 4);
            play_turn(n, mode, starts, tp, pw, ft, fb);
            n_cmp++;
            if (starts !== 1 || tp !== 8'(exp_power(n)) || pw !== 8'(exp_power(n))) begin
                n_err++; $display("FAIL rand_launch_t%0d: got starts=%0d tp=%0d pw=%0d expected 1/%0d/%0d",
                                  t, starts, tp, pw, exp_power(n), exp_power(n));
            end
            n_cmp++;
            if (ft !== ((m_turn == 1) ? 2'b10 : 2'b01) || fb !== 1'b1) begin
                n_err++; $display("FAIL rand_flight_turn_t%0d: got %b/%b expected turn %0d/1", t, ft, fb, m_turn);
            end
            model_resolve((mode == 1 || mode == 2 || mode == 4) ? 1 : 0);
            n_cmp++;
            if (hp_dog !== 8'(m_hp[0]) || hp_cat !== 8'(m_hp[1])) begin
                n_err++; $display("FAIL rand_hp_t%0d mode%0d: got %0d/%0d expected %0d/%0d", t, mode, hp_dog, hp_cat, m_hp[0], m_hp[1]);
            end
            if (m_over != 0) begin
                tick();
                n_cmp++;
                if (game_over !== 1'b1 || winner !== 1'(m_winner) || {cat_turn, dog_turn} !== 2'b00) begin
                    n_err++; $display("FAIL rand_over: got go=%b win=%b expected 1/%0d", game_over, winner, m_winner);
                end
            end else begin
                run_gap(f59);
                model_gap();
                n_cmp++;
                if (f59 !== 1'b0 || {cat_turn, dog_turn} !== ((m_turn == 1) ? 2'b10 : 2'b01)) begin
                    n_err++; $display("FAIL rand_gap_t%0d: got late=%b turns=%b expected 0/turn %0d", t, f59, {cat_turn, dog_turn}, m_turn);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; space = 1'b0; frame_tick = 1'b0; throw_done = 1'b0; hit = 1'b0;
        model_reset();
        test_reset();
        test_basic_throw();
        test_saturation();
        test_hit_same_cycle();
        test_timeout();
        test_game_over();
        test_reset_mid();
        test_random_match();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
